// File: rtl/expr_eval_fsm_if.sv
// Character-stream bus for expr_eval_fsm.
//   in        : ASCII character from the producer
//   in_valid  : qualifies `in`; nothing is consumed while low
//   out       : stream so far is a complete, legal expression
//   dead      : stream hit an illegal character or a limit (sticky)
//   value     : left-to-right result, meaningful while out=1
//   op_count  : operators accepted so far
// master = character producer / result consumer, slave = the recogniser.
interface expr_eval_fsm_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 7
);
    localparam int OPC_W = $clog2(MAX_OPS + 1);

    logic [7:0]       in;
    logic             in_valid;
    logic             out;
    logic             dead;
    logic [WIDTH-1:0] value;
    logic [OPC_W-1:0] op_count;

    modport master (
        output in, in_valid,
        input  out, dead, value, op_count
    );

    modport slave (
        input  in, in_valid,
        output out, dead, value, op_count
    );
endinterface

// File: rtl/expr_eval_fsm.sv
// Expression recogniser/evaluator for an ASCII character stream.
// Accepts operand (op operand)* where an operand is 1..MAX_DIGITS decimal
// digits and op is '+', '-' or '*'. Evaluates strictly left to right,
// modulo 2^WIDTH.
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset, wins over in_valid
//   bus : expr_eval_fsm_if.slave (in, in_valid -> out, dead, value, op_count)
// All outputs are registered; a character accepted at an edge shows up
// on the outputs right after that edge.
module expr_eval_fsm #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int MAX_OPS    = 7
) (
    input logic           clk,
    input logic           clr,
    expr_eval_fsm_if.slave bus
);
    localparam int OPC_W = $clog2(MAX_OPS + 1);
    localparam int DIG_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {START, NUM, OP, DEAD} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} arith_t;

    state_t           state, state_n;
    arith_t           pend, pend_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] cur, cur_n;
    logic [WIDTH-1:0] value, value_n;
    logic [DIG_W-1:0] digits, digits_n;
    logic [OPC_W-1:0] opc, opc_n;
    logic             out_q, dead_q;

    logic [7:0]       diff;
    logic [3:0]       d;
    logic             is_digit, is_op;
    arith_t           in_op;
    logic [WIDTH-1:0] cur_first, cur_ext;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] a,
        input arith_t           op,
        input logic [WIDTH-1:0] b
    );
        case (op)
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return a + b;
        endcase
    endfunction

    // cur*10 + d done as shifts so everything stays WIDTH bits (wraps mod 2^WIDTH)
    function automatic logic [WIDTH-1:0] mul10_add(
        input logic [WIDTH-1:0] c,
        input logic [3:0]       dig
    );
        return (c << 3) + (c << 1) + WIDTH'(dig);
    endfunction

    // Character classification
    always_comb begin
        diff     = bus.in - 8'h30;
        d        = diff[3:0];
        is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_op    = (bus.in == 8'h2B) || (bus.in == 8'h2D) || (bus.in == 8'h2A);
        case (bus.in)
            8'h2D:   in_op = OP_SUB;
            8'h2A:   in_op = OP_MUL;
            default: in_op = OP_ADD;
        endcase
        cur_first = WIDTH'(d);
        cur_ext   = mul10_add(cur, d);
    end

    // Next-state and datapath updates
    always_comb begin
        state_n  = state;
        pend_n   = pend;
        acc_n    = acc;
        cur_n    = cur;
        value_n  = value;
        digits_n = digits;
        opc_n    = opc;
        if (bus.in_valid) begin
            case (state)
                // START behaves like OP with acc=0 and pending '+', so the
                // first operand's value falls out of the same rule.
                START, OP: begin
                    if (is_digit) begin
                        state_n  = NUM;
                        cur_n    = cur_first;
                        digits_n = DIG_W'(1);
                        value_n  = apply_op(acc, pend, cur_first);
                    end else begin
                        state_n = DEAD;
                    end
                end
                NUM: begin
                    if (is_digit) begin
                        if (digits < DIG_W'(MAX_DIGITS)) begin
                            cur_n    = cur_ext;
                            digits_n = digits + DIG_W'(1);
                            value_n  = apply_op(acc, pend, cur_ext);
                        end else begin
                            state_n = DEAD;
                        end
                    end else if (is_op) begin
                        if (opc < OPC_W'(MAX_OPS)) begin
                            state_n  = OP;
                            acc_n    = value;
                            pend_n   = in_op;
                            cur_n    = '0;
                            digits_n = '0;
                            opc_n    = opc + OPC_W'(1);
                        end else begin
                            state_n = DEAD;
                        end
                    end else begin
                        state_n = DEAD;
                    end
                end
                default: state_n = DEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= START;
            pend   <= OP_ADD;
            acc    <= '0;
            cur    <= '0;
            value  <= '0;
            digits <= '0;
            opc    <= '0;
            out_q  <= 1'b0;
            dead_q <= 1'b0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            acc    <= acc_n;
            cur    <= cur_n;
            value  <= value_n;
            digits <= digits_n;
            opc    <= opc_n;
            out_q  <= (state_n == NUM);
            dead_q <= (state_n == DEAD);
        end
    end

    assign bus.out      = out_q;
    assign bus.dead     = dead_q;
    assign bus.value    = value;
    assign bus.op_count = opc;
endmodule

// File: tb/tb_expr_eval_fsm.sv
// Directed bench for expr_eval_fsm (WIDTH=8, MAX_DIGITS=3, MAX_OPS=2).
// Each step drives one cycle of stimulus and pushes the expected outputs
// onto a scoreboard queue; the entry is popped and compared after the edge.
module tb_expr_eval_fsm;
    typedef struct {
        string      tag;
        logic       out;
        logic       dead;
        logic [7:0] value;
        logic [1:0] opc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    expr_eval_fsm_if #(.WIDTH(8), .MAX_OPS(2)) bus ();

    expr_eval_fsm #(.WIDTH(8), .MAX_DIGITS(3), .MAX_OPS(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    task automatic step(input string tag, input logic c, input logic v,
                        input byte ch, input logic eo, input logic ed,
                        input logic [7:0] ev, input logic [1:0] eop);
        exp_t e;
        exp_t got;
        @(negedge clk);
        clr          = c;
        bus.in_valid = v;
        bus.in       = ch;
        e.tag = tag; e.out = eo; e.dead = ed; e.value = ev; e.opc = eop;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        assert (bus.out === got.out && bus.dead === got.dead &&
                bus.value === got.value && bus.op_count === got.opc)
            passed++;
        else begin
            failed++;
            $error("FAIL %s: got out=%b dead=%b value=%0d op_count=%0d, want out=%b dead=%b value=%0d op_count=%0d",
                   got.tag, bus.out, bus.dead, bus.value, bus.op_count,
                   got.out, got.dead, got.value, got.opc);
        end
        clr = 1'b0;
    endtask

    // One accepted character
    task automatic ch(input string tag, input byte c, input logic eo,
                      input logic ed, input logic [7:0] ev, input logic [1:0] eop);
        step(tag, 1'b0, 1'b1, c, eo, ed, ev, eop);
    endtask

    // Reset with a live character that must be discarded
    task automatic rst(input string tag);
        step(tag, 1'b1, 1'b1, "9", 1'b0, 1'b0, 8'd0, 2'd0);
    endtask

    initial begin
        bus.in       = 8'h00;
        bus.in_valid = 1'b0;

        rst("reset");

        // "12+3*4"
        ch("a1",  "1", 1, 0, 8'd1,  2'd0);
        ch("a12", "2", 1, 0, 8'd12, 2'd0);
        ch("a+",  "+", 0, 0, 8'd12, 2'd1);
        ch("a3",  "3", 1, 0, 8'd15, 2'd1);
        ch("a*",  "*", 0, 0, 8'd15, 2'd2);
        ch("a4",  "4", 1, 0, 8'd60, 2'd2);
        rst("clr_a");

        // "200*2" -> 400 mod 256
        ch("b2",   "2", 1, 0, 8'd2,   2'd0);
        ch("b20",  "0", 1, 0, 8'd20,  2'd0);
        ch("b200", "0", 1, 0, 8'd200, 2'd0);
        ch("b*",   "*", 0, 0, 8'd200, 2'd1);
        ch("b2b",  "2", 1, 0, 8'd144, 2'd1);
        rst("clr_b");

        // "3-5" wraps
        ch("c3", "3", 1, 0, 8'd3,   2'd0);
        ch("c-", "-", 0, 0, 8'd3,   2'd1);
        ch("c5", "5", 1, 0, 8'd254, 2'd1);
        rst("clr_c");

        // "12345": fourth digit exceeds MAX_DIGITS, DEAD is sticky
        ch("d1",   "1", 1, 0, 8'd1,   2'd0);
        ch("d12",  "2", 1, 0, 8'd12,  2'd0);
        ch("d123", "3", 1, 0, 8'd123, 2'd0);
        ch("d4",   "4", 0, 1, 8'd123, 2'd0);
        ch("d5",   "5", 0, 1, 8'd123, 2'd0);
        rst("clr_in_dead");

        // "+1"
        ch("e+", "+", 0, 1, 8'd0, 2'd0);
        ch("e1", "1", 0, 1, 8'd0, 2'd0);
        rst("clr_e");

        // "1++2"
        ch("f1",  "1", 1, 0, 8'd1, 2'd0);
        ch("f+",  "+", 0, 0, 8'd1, 2'd1);
        ch("f++", "+", 0, 1, 8'd1, 2'd1);
        ch("f2",  "2", 0, 1, 8'd1, 2'd1);
        rst("clr_f");

        // "1a"
        ch("g1", "1", 1, 0, 8'd1, 2'd0);
        ch("ga", "a", 0, 1, 8'd1, 2'd0);
        rst("clr_g");

        // "1+" incomplete but legal prefix
        ch("h1", "1", 1, 0, 8'd1, 2'd0);
        ch("h+", "+", 0, 0, 8'd1, 2'd1);
        rst("clr_h");

        // "1+1+1+1" with MAX_OPS=2
        ch("i1a", "1", 1, 0, 8'd1, 2'd0);
        ch("i+a", "+", 0, 0, 8'd1, 2'd1);
        ch("i1b", "1", 1, 0, 8'd2, 2'd1);
        ch("i+b", "+", 0, 0, 8'd2, 2'd2);
        ch("i1c", "1", 1, 0, 8'd3, 2'd2);
        ch("i+c", "+", 0, 1, 8'd3, 2'd2);
        ch("i1d", "1", 0, 1, 8'd3, 2'd2);
        rst("clr_i");

        // "12" then three idle cycles with a digit on the bus
        ch("j1",  "1", 1, 0, 8'd12 - 8'd11, 2'd0);
        ch("j12", "2", 1, 0, 8'd12, 2'd0);
        for (int k = 0; k < 3; k++)
            step("idle", 1'b0, 1'b0, "9", 1, 0, 8'd12, 2'd0);
        rst("clr_in_num");
        ch("k7", "7", 1, 0, 8'd7, 2'd0);

        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/expr_eval_fsm.md
Name: expr_eval_fsm

Overview:
- Parametrised successor to the single-digit expression recogniser. Consumes one ASCII character per accepted cycle and checks that the stream so far forms an expression: operand (op operand)*.
- An operand is 1..MAX_DIGITS decimal digits. Operators are '+', '-' and '*'.
- Also evaluates the expression strictly left to right (no precedence), modulo 2^WIDTH.
- Sits in the character-stream datapath next to the other string-recognition FSMs.

Parameters:
- WIDTH, 8: width of the accumulator, operand register and value output; all arithmetic is mod 2^WIDTH.
- MAX_DIGITS, 3: maximum number of digits per operand, >= 1.
- MAX_OPS, 7: maximum number of operators per expression, >= 1.

Ports:
- clk  input  1  clock; rising edge.
- clr  input  1  reset, synchronous, active-high.
- in  input  8  ASCII character.
- in_valid  input  1  character-valid qualifier; `in` is sampled only when in_valid=1.
- out  output  1  1 = characters consumed so far form a complete, legal expression.
- dead  output  1  1 = an illegal character or limit was hit; sticky until clr.
- value  output  WIDTH  left-to-right result of the expression; meaningful when out=1.
- op_count  output  $clog2(MAX_OPS+1)  number of operators accepted so far.

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset clr is synchronous, active-high, and takes priority over in_valid.
  - clr=1 at a rising edge puts the FSM in START and clears acc, cur, digit count and op_count.
  - After clr: pending_op='+', out=0, dead=0, value=0, op_count=0.
  - All outputs are registered. A character accepted at edge N is reflected in the outputs from edge N onward, i.e. visible in the cycle after it was presented.
  - in_valid=0: no state, register or output changes.
- Character classes: digit = "0".."9", d = in-"0". Operator = "+", "-", "*". Anything else is illegal.
- States: START, NUM, OP, DEAD. out=1 iff state==NUM; dead=1 iff state==DEAD.
- START:
  - digit -> NUM, cur=d, digits=1.
  - operator or illegal -> DEAD.
- NUM:
  - digit with digits<MAX_DIGITS -> NUM, cur=cur*10+d, digits+1.
  - digit with digits==MAX_DIGITS -> DEAD.
  - operator with op_count<MAX_OPS -> OP, acc=value, pending_op=in, cur=0, digits=0, op_count+1.
  - operator with op_count==MAX_OPS -> DEAD.
  - illegal -> DEAD.
- OP:
  - digit -> NUM, cur=d, digits=1.
  - operator or illegal -> DEAD.
- DEAD: absorbing. Only clr leaves it.
- Value rule: on every digit accepted into NUM, value <= acc pending_op cur_new.
  - '+' is addition, '-' is subtraction (two's-complement wrap), '*' is multiplication keeping the low WIDTH bits.
  - cur*10+d is also truncated to WIDTH bits.
- On entering OP or DEAD, value holds its last value. out=0 marks it as not a complete expression.
- Mid-operation clr (any state, including DEAD) behaves exactly as reset; the character presented in the same cycle is discarded.
- An empty stream (START) gives out=0, dead=0.

Test Plan:
- WIDTH=8: "12+3*4", one char per cycle -> out 1,1,0,1,0,1; value 1,12,12,15,15,60; op_count ends at 2; dead=0.
- WIDTH=8: "200*2" -> out=1, value=144 (400 mod 256); "3-5" -> value=254.
- MAX_DIGITS=3: "1234" -> after '3' out=1, value=123; after '4' dead=1, out=0. Further digits keep dead=1.
- "+1", "1++2", "1a" and "1+" -> DEAD on the '+', second '+' and 'a' respectively; "1+" ends out=0, dead=0, op_count=1.
- MAX_OPS=2: "1+1+1+1" -> dead=1 on the third '+'.
- "12", then in_valid=0 for 3 cycles with in="9" -> outputs unchanged (value=12).
- clr mid-stream in DEAD and in NUM -> next cycle out=0, dead=0, value=0, op_count=0; "7" then gives out=1, value=7.
